// File: rtl/add_accum_unit.sv
// rtl/add_accum_unit.sv - handshaked WIDTH-bit add/sub/accumulate unit with registered result; ADD_ACCUM_SAT_EN selects saturating arithmetic
module add_accum_unit #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     result,
    output logic                 carry,
    output logic                 ovf_sticky,
    output logic [CNT_WIDTH-1:0] count
);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ACC = 2'b10,
        OP_CLR = 2'b11
    } op_e;

    // Output-valid bit is the whole control state: 0 = EMPTY, 1 = FULL.
    logic                 valid_q,  valid_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 carry_q,  carry_d;
    logic                 sticky_q, sticky_d;
    logic [WIDTH-1:0]     acc_q,    acc_d;
    logic [CNT_WIDTH-1:0] count_q,  count_d;

    logic                 accept;
    logic [WIDTH:0]       add_w;
    logic [WIDTH:0]       sub_w;
    logic [WIDTH:0]       acc_w;
    logic [WIDTH-1:0]     add_res;
    logic [WIDTH-1:0]     sub_res;
    logic [WIDTH-1:0]     acc_res;

    // The output register may be refilled in the same cycle it drains.
    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // WIDTH+1-bit unsigned arithmetic; the top bit is carry-out or borrow.
    always_comb begin
        add_w = {1'b0, a} + {1'b0, b};
        sub_w = {1'b0, a} - {1'b0, b};
        acc_w = {1'b0, acc_q} + {1'b0, a};
    end

`ifdef ADD_ACCUM_SAT_EN
    // Clamp to the representable range when the carry/borrow bit is set.
    always_comb begin
        add_res = add_w[WIDTH] ? {WIDTH{1'b1}} : add_w[WIDTH-1:0];
        sub_res = sub_w[WIDTH] ? {WIDTH{1'b0}} : sub_w[WIDTH-1:0];
        acc_res = acc_w[WIDTH] ? {WIDTH{1'b1}} : acc_w[WIDTH-1:0];
    end
`else
    // Plain modulo-2^WIDTH wrap-around.
    always_comb begin
        add_res = add_w[WIDTH-1:0];
        sub_res = sub_w[WIDTH-1:0];
        acc_res = acc_w[WIDTH-1:0];
    end
`endif

    // Next-state: load the output stage on accept, otherwise drain or hold.
    always_comb begin
        valid_d  = valid_q;
        result_d = result_q;
        carry_d  = carry_q;
        sticky_d = sticky_q;
        acc_d    = acc_q;
        count_d  = count_q;
        if (accept) begin
            valid_d = 1'b1;
            count_d = count_q + CNT_WIDTH'(1);
            case (op_e'(op))
                OP_ADD: begin
                    result_d = add_res;
                    carry_d  = add_w[WIDTH];
                end
                OP_SUB: begin
                    result_d = sub_res;
                    carry_d  = sub_w[WIDTH];
                end
                OP_ACC: begin
                    result_d = acc_res;
                    carry_d  = acc_w[WIDTH];
                    acc_d    = acc_res;
                end
                default: begin
                    result_d = '0;
                    carry_d  = 1'b0;
                    acc_d    = '0;
                end
            endcase
            if (op_e'(op) == OP_CLR) begin
                sticky_d = 1'b0;
            end else begin
                sticky_d = sticky_q | carry_d;
            end
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset; reset drops any pending result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            sticky_q <= 1'b0;
            acc_q    <= '0;
            count_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            sticky_q <= sticky_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
        end
    end

    assign out_valid  = valid_q;
    assign result     = result_q;
    assign carry      = carry_q;
    assign ovf_sticky = sticky_q;
    assign count      = count_q;

endmodule
